hps_fifo_wr_ctrl: RTL and testbench

- Avalon-MM slave controller that sequences HPS writes into an external write-side FIFO.
- Stages HPS words in a small internal buffer. Drains the buffer into the FIFO one word at a time and honours the FIFO's wrfull flag.
- Captures overflow, wrfull-rising and drain-complete events into an edge-capture register with a maskable IRQ.
- Sits between the HPS lightweight bridge and the FIFO write port; all of it runs in the FIFO write-clock domain.

---
 rtl/hps_fifo_wr_ctrl_if.sv | 24 ++
 rtl/hps_fifo_wr_ctrl.sv | 142 ++++++++++++++
 tb/tb_hps_fifo_wr_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_fifo_wr_ctrl_if.sv
// hps_fifo_wr_ctrl_if: Avalon-MM slave bus plus external FIFO write port
interface hps_fifo_wr_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic              fifo_wrfull;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_data;

    modport slave (
        input  address, chipselect, write_n, writedata, fifo_wrfull,
        output readdata, irq, fifo_wrreq, fifo_data
    );

    modport master (
        output address, chipselect, write_n, writedata, fifo_wrfull,
        input  readdata, irq, fifo_wrreq, fifo_data
    );
endinterface

// File: rtl/hps_fifo_wr_ctrl.sv
// hps_fifo_wr_ctrl: stages HPS writes in a small buffer and drains them into a write-side FIFO
module hps_fifo_wr_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    hps_fifo_wr_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, GAP = 2'd2} state_t;

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] L_ONE   = (PTR_W+1)'(1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_drain_en;
    logic [2:0]        r_irq_mask;
    logic [2:0]        r_edge;
    logic              r_wrfull_d1;
    logic              r_irq;
    logic [31:0]       r_readdata;
    logic              r_fifo_wrreq;
    logic [DATA_W-1:0] r_fifo_data;

    logic              w_wr;
    logic              w_push;
    logic              w_push_ok;
    logic              w_flush;
    logic              w_clear;
    logic              w_pop;
    logic              w_go;
    logic              w_empty;
    logic              w_full;
    logic [2:0]        w_events;
    logic [31:0]       w_rdata;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_push    = w_wr & (bus.address == 2'd0);
    assign w_flush   = w_wr & (bus.address == 2'd1) & bus.writedata[1];
    assign w_clear   = w_wr & (bus.address == 2'd3);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == L_DEPTH);
    // occupancy is judged before this cycle's pop, so a full buffer drops the word even while draining
    assign w_push_ok = w_push & ~w_full & ~w_flush;
    assign w_pop     = (r_state == WRITE) & ~w_empty;
    // a flush in the deciding cycle empties the buffer, so no new WRITE may start on stale contents
    assign w_go      = r_drain_en & ~w_empty & ~bus.fifo_wrfull & ~w_flush;
    assign w_events  = {w_pop & (r_count == L_ONE) & ~w_push_ok & ~w_flush,
                        bus.fifo_wrfull & ~r_wrfull_d1,
                        w_push & w_full & ~w_flush};

    // drain FSM next state: every WRITE is followed by a GAP so the FIFO can update wrfull
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? WRITE : IDLE;
            WRITE:   w_next = GAP;
            GAP:     w_next = w_go ? WRITE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // register read mux, sampled into readdata every cycle
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            2'd0:    w_rdata = {18'b0, r_state, 1'b0, bus.fifo_wrfull, w_full, w_empty, 8'(r_count)};
            2'd1:    w_rdata = {31'b0, r_drain_en};
            2'd2:    w_rdata = {29'b0, r_irq_mask};
            default: w_rdata = {29'b0, r_edge};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // staging buffer storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= bus.writedata[DATA_W-1:0];
    end

    // buffer pointers and occupancy; flush overrides any push or pop this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= r_count + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop};
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, w_push_ok};
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, w_pop};
        end
    end

    // control/mask registers, edge capture (clear dominates set) and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drain_en  <= 1'b0;
            r_irq_mask  <= '0;
            r_edge      <= '0;
            r_wrfull_d1 <= 1'b0;
            r_irq       <= 1'b0;
            r_readdata  <= '0;
        end else begin
            if (w_wr && bus.address == 2'd1) r_drain_en <= bus.writedata[0];
            if (w_wr && bus.address == 2'd2) r_irq_mask <= bus.writedata[2:0];
            r_edge      <= w_clear ? 3'b0 : (r_edge | w_events);
            r_wrfull_d1 <= bus.fifo_wrfull;
            r_irq       <= |(r_edge & r_irq_mask);
            r_readdata  <= w_rdata;
        end
    end

    // FIFO write port, registered so wrreq and data are stable for the whole WRITE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_wrreq <= 1'b0;
            r_fifo_data  <= '0;
        end else begin
            r_fifo_wrreq <= (w_next == WRITE);
            if (w_next == WRITE) r_fifo_data <= r_mem[r_rd_ptr];
        end
    end

    assign bus.readdata   = r_readdata;
    assign bus.irq        = r_irq;
    assign bus.fifo_wrreq = r_fifo_wrreq;
    assign bus.fifo_data  = r_fifo_data;
endmodule

// File: tb/tb_hps_fifo_wr_ctrl.sv
// tb_hps_fifo_wr_ctrl: directed and random checks of hps_fifo_wr_ctrl against a queue-based model
module tb_hps_fifo_wr_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    hps_fifo_wr_ctrl_if #(.DATA_W(32)) bus ();

    hps_fifo_wr_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // model state: buffer contents as a queue, plus visible registers
    logic [31:0] mq [$];
    logic [31:0] got [$];
    logic        m_drain = 1'b0;
    logic [2:0]  m_mask = '0;
    logic [2:0]  m_edge = '0;
    logic        m_irq = 1'b0;
    logic [31:0] m_rd = '0;
    logic        m_wrreq = 1'b0;
    logic [31:0] m_data = '0;
    int          m_phase = 0;
    logic        m_d1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain = 1'b0; m_mask = '0; m_edge = '0; m_irq = 1'b0; m_rd = '0;
        m_wrreq = 1'b0; m_data = '0; m_phase = 0; m_d1 = 1'b0;
    endtask

    // advances the model by one clock using the inputs that the coming posedge will sample
    task automatic model_step();
        logic        wr, push, flush, clr, pop, acc, go, wf;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [2:0]  ev;
        int          n, nphase;
        wr = bus.chipselect & ~bus.write_n;
        a = bus.address; wd = bus.writedata; wf = bus.fifo_wrfull;
        n = mq.size();
        push = wr && a == 2'd0;
        flush = wr && a == 2'd1 && wd[1];
        clr = wr && a == 2'd3;
        pop = m_phase == 1 && n > 0;
        acc = push && n < DEPTH && !flush;
        ev = {pop && n == 1 && !acc && !flush, wf && !m_d1, push && n == DEPTH && !flush};
        case (a)
            2'd0: m_rd = {18'b0, 2'(m_phase), 1'b0, wf, n == DEPTH, n == 0, 8'(n)};
            2'd1: m_rd = {31'b0, m_drain};
            2'd2: m_rd = {29'b0, m_mask};
            default: m_rd = {29'b0, m_edge};
        endcase
        m_irq = |(m_edge & m_mask);
        go = m_drain && n > 0 && !wf && !flush;
        nphase = (m_phase == 1) ? 2 : (go ? 1 : 0);
        if (nphase == 1) m_data = mq[0];
        m_wrreq = (nphase == 1);
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(wd);
        end
        m_edge = clr ? 3'b0 : (m_edge | ev);
        if (wr && a == 2'd1) m_drain = wd[0];
        if (wr && a == 2'd2) m_mask = wd[2:0];
        m_d1 = wf;
        m_phase = nphase;
    endtask

    // compare process: outputs are checked mid-cycle against the model, then the model advances
    always @(negedge clk) begin
        if (!reset_n) model_reset();
        check("readdata", bus.readdata, m_rd);
        check("irq", {31'b0, bus.irq}, {31'b0, m_irq});
        check("fifo_wrreq", {31'b0, bus.fifo_wrreq}, {31'b0, m_wrreq});
        check("fifo_data", bus.fifo_data, m_data);
        if (!reset_n) model_reset();
        else model_step();
    end

    // collects every word the DUT hands to the FIFO
    always @(negedge clk) begin
        if (reset_n && bus.fifo_wrreq) got.push_back(bus.fifo_data);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
    endtask

    task automatic wait_got(input int n, input int limit);
        int k = 0;
        while (got.size() < n && k < limit) begin
            tick(1);
            k++;
        end
    endtask

    task automatic rand_cycle();
        int r = $urandom_range(0, 99);
        bus.address = 2'($urandom_range(0, 3));
        if (r < 35) begin
            bus.address = 2'd0; bus.writedata = $urandom; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        end else if (r < 45) begin
            bus.address = 2'd1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
            bus.writedata = {30'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0};
        end else if (r < 50) begin
            bus.address = 2'd2; bus.writedata = $urandom; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        end else if (r < 53) begin
            bus.address = 2'd3; bus.writedata = $urandom; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        end else if (r < 56) begin
            bus.chipselect = 1'b1; bus.write_n = 1'b1;
        end
        if ($urandom_range(0, 9) == 0) bus.fifo_wrfull = ~bus.fifo_wrfull;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.writedata = '0; bus.fifo_wrfull = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // reset values seen through the register map
        bus_read(2'd0, rd); check("rst_status", rd, 32'h0000_0100);
        bus_read(2'd1, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(2'd2, rd); check("rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_edge", rd, 32'h0);
        check("rst_wrreq", {31'b0, bus.fifo_wrreq}, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);

        // basic drain of three words ends with a drain-complete event
        got.delete();
        bus_write(2'd0, 32'h11); bus_write(2'd0, 32'h22); bus_write(2'd0, 32'h33);
        bus_write(2'd1, 32'h1);
        wait_got(3, 30);
        tick(4);
        check("drain_n", got.size(), 3);
        check("drain_w0", got[0], 32'h11);
        check("drain_w1", got[1], 32'h22);
        check("drain_w2", got[2], 32'h33);
        bus_read(2'd0, rd); check("drain_status", rd, 32'h0000_0100);
        bus_read(2'd3, rd); check("drain_edge", rd, 32'h4);

        // overflow: ninth push dropped, irq follows the mask
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'hA0 + i);
        bus_read(2'd0, rd); check("ovf_status", rd, 32'h0000_0208);
        bus_read(2'd3, rd); check("ovf_edge", rd, 32'h1);
        bus_write(2'd2, 32'h1);
        tick(1);
        check("ovf_irq_on", {31'b0, bus.irq}, 32'h1);
        bus_write(2'd3, 32'h0);
        tick(1);
        check("ovf_irq_off", {31'b0, bus.irq}, 32'h0);
        bus_read(2'd3, rd); check("ovf_edge_clr", rd, 32'h0);

        // wrfull stalls the drain after two words, then it resumes in order
        got.delete();
        bus_write(2'd1, 32'h1);
        wait_got(2, 30);
        bus.fifo_wrfull = 1'b1;
        tick(10);
        check("stall_n", got.size(), 2);
        bus_read(2'd0, rd); check("stall_status", rd, 32'h0000_0406);
        bus_read(2'd3, rd); check("stall_edge", rd, 32'h2);
        bus.fifo_wrfull = 1'b0;
        wait_got(8, 40);
        check("resume_n", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("resume_word", got[i], 32'hA0 + i);

        // flush during a WRITE: that word still goes out, nothing else does
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'h0);
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'hB0 + i);
        got.delete();
        bus_write(2'd1, 32'h1);
        tick(1);
        check("flush_in_write", {31'b0, bus.fifo_wrreq}, 32'h1);
        bus_write(2'd1, 32'h3);
        tick(8);
        check("flush_n", got.size(), 1);
        check("flush_word", got.size() > 0 ? got[0] : 32'hDEAD_BEEF, 32'hB0);
        bus_read(2'd0, rd); check("flush_status", rd, 32'h0000_0100);
        bus_read(2'd3, rd); check("flush_edge", rd, 32'h0);

        // random traffic, checked cycle by cycle by the model
        for (int i = 0; i < 1500; i++) rand_cycle();
        bus.fifo_wrfull = 1'b0;
        bus_write(2'd1, 32'h2);
        tick(4);
        bus_write(2'd3, 32'h0);

        // push concurrent with pop at count 3
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'hC0 + i);
        got.delete();
        bus_write(2'd1, 32'h1);
        tick(1);
        bus_write(2'd0, 32'hC3);
        bus_read(2'd0, rd); check("pushpop_status", rd, 32'h0000_2003);
        wait_got(4, 30);
        check("pushpop_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("pushpop_word", got[i], 32'hC0 + i);

        // asynchronous reset in the middle of a WRITE
        tick(4);
        bus_write(2'd0, 32'hD0);
        k = 0;
        while (!bus.fifo_wrreq && k < 20) begin
            tick(1);
            k++;
        end
        check("pre_reset_wrreq", {31'b0, bus.fifo_wrreq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_wrreq", {31'b0, bus.fifo_wrreq}, 32'h0);
        check("async_data", bus.fifo_data, 32'h0);
        check("async_rd", bus.readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        bus_read(2'd0, rd); check("post_status", rd, 32'h0000_0100);
        bus_read(2'd1, rd); check("post_ctrl", rd, 32'h0);
        bus_read(2'd2, rd); check("post_mask", rd, 32'h0);
        bus_read(2'd3, rd); check("post_edge", rd, 32'h0);
        check("post_irq", {31'b0, bus.irq}, 32'h0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
